systolic_mm_engine: RTL and testbench
=====================================

Name: systolic_mm_engine

Overview:
- Parametrised N x N output-stationary systolic matrix multiplier: C = A x B.
- Successor to the fixed 4x4 array. Adds:
  - generic dimension and widths;
  - internal input skewing;
  - a start/busy/done FSM;
  - a valid/ready operand stream with bubble tolerance;
  - signed/unsigned mode;
  - backpressured row-by-row result readout.
- Sits between the operand DMA/buffer and the result writeback path.

Parameters:
- N, default 4: array dimension (N >= 2).
- DATA_WIDTH, default 8: operand width.
- ACC_WIDTH, default 2*DATA_WIDTH+$clog2(N): accumulator width. Must be >= 2*DATA_WIDTH; elaboration error otherwise.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- start_i  in  1  start a new multiply; sampled in IDLE only.
- signed_i  in  1  1 = two's-complement operands; latched on accepted start.
- in_valid_i  in  1  operand beat valid.
- in_ready_o  out  1  beat accepted when in_valid_i & in_ready_o.
- a_col_i  in  N*DATA_WIDTH  column k of A; element i at bits [i*DW +: DW].
- b_row_i  in  N*DATA_WIDTH  row k of B; element j at bits [j*DW +: DW].
- res_valid_o  out  1  result row valid.
- res_ready_i  in  1  result row consumed when res_valid_o & res_ready_i.
- res_row_o  out  N*ACC_WIDTH  row r of C; element j at bits [j*ACC_WIDTH +: ACC_WIDTH].
- res_idx_o  out  $clog2(N)  index r of the presented row.
- busy_o  out  1  high in any state but IDLE.
- done_o  out  1  one-cycle pulse after the last row is consumed.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, accumulators, skew and pipeline registers cleared. Reset mid-operation aborts: no done_o, partial results discarded.
- FSM states: IDLE, LOAD, DRAIN, READ.
- IDLE:
  - start_i=1 latches signed_i, clears accumulators, skew and pipe registers, then moves to LOAD.
  - in_ready_o=0.
- LOAD:
  - in_ready_o=1.
  - Accepts exactly N beats; beat k carries A[*][k] and B[k][*].
  - After beat N-1 is accepted, moves to DRAIN.
- DRAIN:
  - Lasts 2N-2 cycles, counted by a cycle counter.
  - in_ready_o=0.
  - After the last cycle, moves to READ.
- READ:
  - res_valid_o=1 and res_row_o = row r, starting at r=0.
  - r advances on each handshake.
  - When row N-1 is consumed: IDLE, with done_o=1 for that next cycle.
- start_i while busy_o=1 is ignored; it is not queued.
- Array advance enable: adv = (LOAD & in_valid_i) | DRAIN. All skew, horizontal, vertical and accumulator registers update only on adv.
  - A cycle with in_valid_i=0 in LOAD freezes the whole array, so bubbles never misalign operands.
- Skew:
  - A element i passes i stages before entering column 0.
  - B element j passes j stages before entering row 0.
  - Zeros enter the skew lines in DRAIN.
- Timing: PE(i,j) performs its MAC for beat k on adv edge k+i+j, counting from 0 at the first beat. The final MAC is on adv edge 3N-3, which is the last DRAIN cycle.
- Each PE forwards its A operand right and its B operand down through registers.
- Arithmetic:
  - Product is 2*DATA_WIDTH, sign- or zero-extended to ACC_WIDTH according to the latched mode.
  - Accumulation wraps modulo 2^ACC_WIDTH; no saturation.
- Readout:
  - res_row_o and res_idx_o are held stable while res_valid_o=1 and res_ready_i=0.
  - res_row_o is 0 outside READ.
- Throughput with in_valid_i and res_ready_i held high: start accepted at edge T gives done_o high in cycle T+4N-1, which is T+15 for N=4. busy_o is high in cycles T+1..T+4N-2.
- Back-to-back operation: start_i may be asserted in the done_o cycle and is accepted.

Test Plan:
1. N=4, DW=8, unsigned; A=identity, B[i][j]=4i+j -> rows 0..3 read {0,1,2,3},{4,5,6,7},{8,9,10,11},{12,13,14,15}; done_o in cycle T+15.
2. Signed; A all 0xFF (-1), B all 0x02 -> every C element = -8 = 0x3FFF8 (ACC_WIDTH=18). The same data with signed_i=0 gives 255*2*4 = 2040 = 0x007F8.
3. Case 1 data with in_valid_i low for 2 cycles between every beat -> identical results; done_o delayed by exactly 6 cycles.
4. res_ready_i low for 3 cycles while row 1 is presented -> row 1 and res_idx_o=1 held stable; no row skipped or duplicated; done_o follows row 3.
5. Assert rst_i for one cycle in DRAIN -> busy_o=0 and all outputs 0 the next cycle, no done_o; a fresh start with case 1 data gives correct results.
6. start_i pulsed during LOAD and READ -> ignored, results unaffected. start_i asserted in the done_o cycle -> second multiply (A=B=all 1 -> all C=4) completes correctly.

Source files
------------

// File: rtl/systolic_mm_engine_if.sv
// -----------------------------------------------------------------------------
// systolic_mm_engine_if
// Groups the control, operand-stream and result-stream signals of the
// systolic matrix multiplier into one bundle.
//
// Signals (direction as seen by the engine, i.e. the slave modport):
//   start_i      in   start a new multiply (sampled in IDLE only)
//   signed_i     in   1 = two's-complement operands, latched on start
//   in_valid_i   in   operand beat valid
//   in_ready_o   out  operand beat accepted when in_valid_i & in_ready_o
//   a_col_i      in   column k of A, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   b_row_i      in   row k of B, element j at [j*DATA_WIDTH +: DATA_WIDTH]
//   res_valid_o  out  result row valid
//   res_ready_i  in   result row consumed when res_valid_o & res_ready_i
//   res_row_o    out  row r of C, element j at [j*ACC_WIDTH +: ACC_WIDTH]
//   res_idx_o    out  index r of the presented row
//   busy_o       out  engine not idle
//   done_o       out  one-cycle pulse after the last row is consumed
// -----------------------------------------------------------------------------
interface systolic_mm_engine_if #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(N)
);
    localparam int IDX_W = $clog2(N);

    logic                      start_i;
    logic                      signed_i;
    logic                      in_valid_i;
    logic                      in_ready_o;
    logic [N*DATA_WIDTH-1:0]   a_col_i;
    logic [N*DATA_WIDTH-1:0]   b_row_i;
    logic                      res_valid_o;
    logic                      res_ready_i;
    logic [N*ACC_WIDTH-1:0]    res_row_o;
    logic [IDX_W-1:0]          res_idx_o;
    logic                      busy_o;
    logic                      done_o;

    // Engine side.
    modport slave (
        input  start_i,
        input  signed_i,
        input  in_valid_i,
        output in_ready_o,
        input  a_col_i,
        input  b_row_i,
        output res_valid_o,
        input  res_ready_i,
        output res_row_o,
        output res_idx_o,
        output busy_o,
        output done_o
    );

    // Operand source / result sink side.
    modport master (
        output start_i,
        output signed_i,
        output in_valid_i,
        input  in_ready_o,
        output a_col_i,
        output b_row_i,
        input  res_valid_o,
        output res_ready_i,
        input  res_row_o,
        input  res_idx_o,
        input  busy_o,
        input  done_o
    );
endinterface

// File: rtl/systolic_mm_engine.sv
// -----------------------------------------------------------------------------
// systolic_mm_engine
// N x N output-stationary systolic matrix multiplier, C = A x B.
// Operands arrive as N beats (column k of A with row k of B), are skewed
// internally, flow right (A) and down (B) through the PE grid, and each PE
// accumulates its own C element. Results are read out row by row over a
// valid/ready stream.
//
// Ports:
//   clk_i   clock, rising edge
//   rst_i   synchronous reset, active-high
//   bus     systolic_mm_engine_if.slave (control, operand and result streams)
//
// FSM:
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | waiting for start_i; start clears the array and latches mode
//   S_LOAD  | accepting N operand beats; array advances only on valid beats
//   S_DRAIN | 2N-2 cycles flushing zeros through the skew/array
//   S_READ  | presenting result rows 0..N-1 on the result stream
// -----------------------------------------------------------------------------
module systolic_mm_engine #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(N)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    systolic_mm_engine_if.slave   bus
);

    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(2 * N);

    if (ACC_WIDTH < 2 * DATA_WIDTH) begin : g_acc_width_check
        $error("systolic_mm_engine: ACC_WIDTH must be >= 2*DATA_WIDTH");
    end
    if (N < 2) begin : g_dim_check
        $error("systolic_mm_engine: N must be >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_READ
    } state_t;

    state_t             state_q;
    logic               signed_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   row_q;
    logic               in_ready_q;
    logic               res_valid_q;
    logic               busy_q;
    logic               done_q;

    logic               adv;
    logic               clr;
    logic               load;

    // Operand entering PE(i,j) from the left / from above.
    logic [DATA_WIDTH-1:0] a_left [N][N];
    logic [DATA_WIDTH-1:0] b_top  [N][N];
    logic [ACC_WIDTH-1:0]  acc    [N][N];

    logic [DATA_WIDTH-1:0] a_feed [N];
    logic [DATA_WIDTH-1:0] b_feed [N];

    logic [N*ACC_WIDTH-1:0] res_row;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    // cnt_q is a down-counter: beats remaining in LOAD, cycles remaining
    // in DRAIN; both phases end on the terminal count of zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            signed_q    <= 1'b0;
            cnt_q       <= '0;
            row_q       <= '0;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start_i) begin
                        signed_q   <= bus.signed_i;
                        cnt_q      <= CNT_W'(N - 1);
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (bus.in_valid_i) begin
                        if (cnt_q == '0) begin
                            cnt_q      <= CNT_W'(2 * N - 3);
                            in_ready_q <= 1'b0;
                            state_q    <= S_DRAIN;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (cnt_q == '0) begin
                        res_valid_q <= 1'b1;
                        row_q       <= '0;
                        state_q     <= S_READ;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_READ: begin
                    if (bus.res_ready_i) begin
                        if (row_q == IDX_W'(N - 1)) begin
                            res_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            row_q       <= '0;
                            state_q     <= S_IDLE;
                        end else begin
                            row_q <= row_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // The whole array moves in lock-step; a missing beat in LOAD freezes it
    // so operands stay aligned regardless of bubbles.
    assign load = (state_q == S_LOAD);
    assign adv  = (load && bus.in_valid_i) || (state_q == S_DRAIN);
    assign clr  = (state_q == S_IDLE) && bus.start_i;

    // Zeros are pushed in during DRAIN so trailing MACs add nothing.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_feed[i] = '0;
            b_feed[i] = '0;
            if (load) begin
                a_feed[i] = bus.a_col_i[i*DATA_WIDTH +: DATA_WIDTH];
                b_feed[i] = bus.b_row_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // Input skew: lane i is delayed by i advance steps
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < N; gi++) begin : g_skew
        if (gi == 0) begin : g_direct
            assign a_left[0][0] = a_feed[0];
            assign b_top[0][0]  = b_feed[0];
        end else begin : g_line
            logic [DATA_WIDTH-1:0] a_sr_q [gi];
            logic [DATA_WIDTH-1:0] b_sr_q [gi];

            always_ff @(posedge clk_i) begin
                if (rst_i || clr) begin
                    for (int s = 0; s < gi; s++) begin
                        a_sr_q[s] <= '0;
                        b_sr_q[s] <= '0;
                    end
                end else if (adv) begin
                    a_sr_q[0] <= a_feed[gi];
                    b_sr_q[0] <= b_feed[gi];
                    for (int s = 1; s < gi; s++) begin
                        a_sr_q[s] <= a_sr_q[s-1];
                        b_sr_q[s] <= b_sr_q[s-1];
                    end
                end
            end

            assign a_left[gi][0] = a_sr_q[gi-1];
            assign b_top[0][gi]  = b_sr_q[gi-1];
        end
    end

    // ------------------------------------------------------------------
    // Processing elements
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_pe
            logic [ACC_WIDTH-1:0]    acc_q;
            logic [2*DATA_WIDTH-1:0] a_ext;
            logic [2*DATA_WIDTH-1:0] b_ext;
            logic [2*DATA_WIDTH-1:0] prod;
            logic [ACC_WIDTH-1:0]    prod_ext;

            // Operands are widened to 2*DW in the latched mode first, so the
            // low 2*DW bits of the product are exact for both signed and
            // unsigned operands; the product is then extended to ACC_WIDTH.
            always_comb begin
                a_ext = signed_q
                      ? {{DATA_WIDTH{a_left[gi][gj][DATA_WIDTH-1]}}, a_left[gi][gj]}
                      : {{DATA_WIDTH{1'b0}}, a_left[gi][gj]};
                b_ext = signed_q
                      ? {{DATA_WIDTH{b_top[gi][gj][DATA_WIDTH-1]}}, b_top[gi][gj]}
                      : {{DATA_WIDTH{1'b0}}, b_top[gi][gj]};
                prod  = a_ext * b_ext;
                prod_ext = signed_q ? ACC_WIDTH'($signed(prod)) : ACC_WIDTH'(prod);
            end

            always_ff @(posedge clk_i) begin
                if (rst_i || clr) begin
                    acc_q <= '0;
                end else if (adv) begin
                    acc_q <= acc_q + prod_ext;
                end
            end

            assign acc[gi][gj] = acc_q;

            if (gj < N - 1) begin : g_fwd_a
                logic [DATA_WIDTH-1:0] a_q;
                always_ff @(posedge clk_i) begin
                    if (rst_i || clr) begin
                        a_q <= '0;
                    end else if (adv) begin
                        a_q <= a_left[gi][gj];
                    end
                end
                assign a_left[gi][gj+1] = a_q;
            end

            if (gi < N - 1) begin : g_fwd_b
                logic [DATA_WIDTH-1:0] b_q;
                always_ff @(posedge clk_i) begin
                    if (rst_i || clr) begin
                        b_q <= '0;
                    end else if (adv) begin
                        b_q <= b_top[gi][gj];
                    end
                end
                assign b_top[gi+1][gj] = b_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result readout: accumulators are frozen outside LOAD/DRAIN, so the
    // selected row is stable for as long as row_q is held.
    // ------------------------------------------------------------------
    always_comb begin
        res_row = '0;
        if (res_valid_q) begin
            for (int j = 0; j < N; j++) begin
                res_row[j*ACC_WIDTH +: ACC_WIDTH] = acc[row_q][j];
            end
        end
    end

    assign bus.in_ready_o  = in_ready_q;
    assign bus.res_valid_o = res_valid_q;
    assign bus.res_row_o   = res_row;
    assign bus.res_idx_o   = row_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;

endmodule

// File: tb/tb_systolic_mm_engine.sv
// -----------------------------------------------------------------------------
// tb_systolic_mm_engine
// Self-checking bench: drives operand beats and consumes result rows through
// the engine interface, comparing against a plain-arithmetic matrix product.
// -----------------------------------------------------------------------------
module tb_systolic_mm_engine;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int ACC   = 2 * DW + $clog2(N);
    localparam int IDX_W = $clog2(N);
    localparam int LAT   = 4 * N - 2;   // edges from start edge to done visible

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    systolic_mm_engine_if #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(ACC)) ifc ();

    systolic_mm_engine #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(ACC)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifc.slave)
    );

    int checks = 0;
    int errors = 0;

    int              a_m [N][N];
    int              b_m [N][N];
    logic [ACC-1:0]  c_exp [N][N];
    logic [N*ACC-1:0] got_row [N];
    int              got_idx [N];
    int              n_got;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic longint to_val(input int v, input bit sgn);
        if (sgn && v >= (1 << (DW - 1)))
            return longint'(v) - (longint'(1) << DW);
        return longint'(v);
    endfunction

    function automatic void compute_model(input bit sgn);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                longint s;
                s = 0;
                for (int k = 0; k < N; k++)
                    s += to_val(a_m[i][k], sgn) * to_val(b_m[k][j], sgn);
                c_exp[i][j] = s[ACC-1:0];
            end
        end
    endfunction

    function automatic void load_case1();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a_m[i][j] = (i == j) ? 1 : 0;
                b_m[i][j] = 4 * i + j;
            end
    endfunction

    function automatic void load_const(input int av, input int bv);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a_m[i][j] = av;
                b_m[i][j] = bv;
            end
    endfunction

    // ------------------------------------------------------------------
    // Transaction driver: runs one multiply, collects accepted rows.
    // gap < 0 selects a random bubble count per beat. extra returns the
    // number of bubble + stall cycles inserted.
    // ------------------------------------------------------------------
    task automatic do_mult(input bit sgn, input int gap, input int stall_row,
                           input int stall_cycles, input bit pulse_start,
                           input bit skip_start, input bit chain,
                           output int done_lat, output int extra,
                           output bit timed_out, output bit hold_bad,
                           output bit busy_bad);
        int e;
        int g;
        int stalls;
        bit done_seen;
        logic [N*ACC-1:0] snap_row;
        logic [IDX_W-1:0] snap_idx;
        timed_out = 0; hold_bad = 0; busy_bad = 0;
        extra = 0; done_lat = -1; n_got = 0; stalls = 0;
        snap_row = '0; snap_idx = '0;
        if (!skip_start) begin
            @(negedge clk);
            ifc.start_i  = 1'b1;
            ifc.signed_i = sgn;
            @(negedge clk);
            ifc.start_i  = 1'b0;
        end
        e = 0;
        for (int k = 0; k < N; k++) begin
            g = (k == 0) ? 0 : ((gap < 0) ? int'($urandom_range(0, 3)) : gap);
            ifc.in_valid_i = 1'b0;
            ifc.a_col_i = $urandom;
            repeat (g) begin
                if (ifc.busy_o !== 1'b1) busy_bad = 1;
                @(negedge clk);
                e++; extra++;
            end
            ifc.in_valid_i = 1'b1;
            for (int i = 0; i < N; i++) begin
                ifc.a_col_i[i*DW +: DW] = DW'(a_m[i][k]);
                ifc.b_row_i[i*DW +: DW] = DW'(b_m[k][i]);
            end
            if (pulse_start && k == 1) ifc.start_i = 1'b1;
            if (ifc.busy_o !== 1'b1) busy_bad = 1;
            @(negedge clk);
            e++;
            ifc.start_i = 1'b0;
        end
        ifc.in_valid_i = 1'b0;
        ifc.a_col_i = $urandom;
        ifc.b_row_i = $urandom;
        done_seen = 0;
        for (int it = 0; it < 200 && !done_seen; it++) begin
            if (ifc.done_o === 1'b1) begin
                done_seen = 1;
                done_lat  = e;
                if (ifc.busy_o !== 1'b0) busy_bad = 1;
                if (chain) begin
                    ifc.start_i  = 1'b1;
                    ifc.signed_i = 1'b0;
                    @(negedge clk);
                    ifc.start_i  = 1'b0;
                end
            end else begin
                if (ifc.busy_o !== 1'b1) busy_bad = 1;
                ifc.res_ready_i = 1'b1;
                if (ifc.res_valid_o === 1'b1) begin
                    if (pulse_start && n_got == 0) ifc.start_i = 1'b1;
                    if (ifc.res_idx_o == stall_row && stalls < stall_cycles) begin
                        if (stalls == 0) begin
                            snap_row = ifc.res_row_o;
                            snap_idx = ifc.res_idx_o;
                        end else if (ifc.res_row_o !== snap_row || ifc.res_idx_o !== snap_idx) begin
                            hold_bad = 1;
                        end
                        ifc.res_ready_i = 1'b0;
                        stalls++; extra++;
                    end else begin
                        if (stalls > 0 && ifc.res_idx_o == stall_row && ifc.res_row_o !== snap_row)
                            hold_bad = 1;
                        if (n_got < N) begin
                            got_row[n_got] = ifc.res_row_o;
                            got_idx[n_got] = int'(ifc.res_idx_o);
                        end
                        n_got++;
                    end
                end
                @(negedge clk);
                ifc.start_i = 1'b0;
                e++;
            end
        end
        if (!done_seen) timed_out = 1;
        ifc.res_ready_i = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        ifc.start_i = 0; ifc.signed_i = 0; ifc.in_valid_i = 0;
        ifc.a_col_i = '0; ifc.b_row_i = '0; ifc.res_ready_i = 0;
        repeat (3) @(negedge clk);
        checks++; if (ifc.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", ifc.busy_o); end
        checks++; if (ifc.in_ready_o !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", ifc.in_ready_o); end
        checks++; if (ifc.res_valid_o !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", ifc.res_valid_o); end
        checks++; if (ifc.res_row_o !== '0) begin errors++; $display("FAIL reset_res_row: got %h expected 0", ifc.res_row_o); end
        checks++; if (ifc.res_idx_o !== '0) begin errors++; $display("FAIL reset_res_idx: got %0d expected 0", ifc.res_idx_o); end
        checks++; if (ifc.done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", ifc.done_o); end
        rst = 1'b0;
        ifc.res_ready_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_identity();
        int dl, ex; bit to, hb, bb;
        load_case1();
        compute_model(1'b0);
        do_mult(1'b0, 0, -1, 0, 1'b0, 1'b0, 1'b0, dl, ex, to, hb, bb);
        checks++; if (to) begin errors++; $display("FAIL ident_timeout: done_o never seen, expected within bound"); end
        checks++; if (dl != LAT) begin errors++; $display("FAIL ident_done_latency: got %0d expected %0d", dl, LAT); end
        checks++; if (bb) begin errors++; $display("FAIL ident_busy: busy_o profile wrong, got flag %0d expected 0", bb); end
        checks++; if (n_got != N) begin errors++; $display("FAIL ident_row_count: got %0d expected %0d", n_got, N); end
        for (int r = 0; r < N; r++) begin
            checks++; if (got_idx[r] != r) begin errors++; $display("FAIL ident_idx%0d: got %0d expected %0d", r, got_idx[r], r); end
            for (int j = 0; j < N; j++) begin
                checks++;
                if (got_row[r][j*ACC +: ACC] !== c_exp[r][j]) begin
                    errors++; $display("FAIL ident_c%0d%0d: got %0h expected %0h", r, j, got_row[r][j*ACC +: ACC], c_exp[r][j]);
                end
            end
        end
        checks++; if (got_row[2][1*ACC +: ACC] !== ACC'(9)) begin errors++; $display("FAIL ident_c21_const: got %0d expected 9", got_row[2][1*ACC +: ACC]); end
    endtask

    task automatic test_signed_mode();
        int dl, ex; bit to, hb, bb;
        logic [ACC-1:0] want;
        for (int m = 0; m < 2; m++) begin
            load_const(8'hFF, 8'h02);
            compute_model(m == 0);
            want = (m == 0) ? ACC'(18'h3FFF8) : ACC'(18'h007F8);
            do_mult(m == 0, 0, -1, 0, 1'b0, 1'b0, 1'b0, dl, ex, to, hb, bb);
            checks++; if (to || n_got != N) begin errors++; $display("FAIL sign%0d_complete: rows %0d timeout %0d expected %0d rows", m, n_got, to, N); end
            for (int r = 0; r < N; r++)
                for (int j = 0; j < N; j++) begin
                    checks++;
                    if (got_row[r][j*ACC +: ACC] !== c_exp[r][j] || c_exp[r][j] !== want) begin
                        errors++; $display("FAIL sign%0d_c%0d%0d: got %0h expected %0h", m, r, j, got_row[r][j*ACC +: ACC], want);
                    end
                end
        end
    endtask

    task automatic test_bubbles();
        int dl, ex; bit to, hb, bb;
        load_case1();
        compute_model(1'b0);
        do_mult(1'b0, 2, -1, 0, 1'b0, 1'b0, 1'b0, dl, ex, to, hb, bb);
        checks++; if (dl != LAT + 6) begin errors++; $display("FAIL bubble_latency: got %0d expected %0d", dl, LAT + 6); end
        checks++; if (to || n_got != N) begin errors++; $display("FAIL bubble_rows: got %0d rows timeout %0d expected %0d", n_got, to, N); end
        for (int r = 0; r < N; r++)
            for (int j = 0; j < N; j++) begin
                checks++;
                if (got_row[r][j*ACC +: ACC] !== c_exp[r][j]) begin
                    errors++; $display("FAIL bubble_c%0d%0d: got %0h expected %0h", r, j, got_row[r][j*ACC +: ACC], c_exp[r][j]);
                end
            end
    endtask

    task automatic test_backpressure();
        int dl, ex; bit to, hb, bb;
        load_case1();
        compute_model(1'b0);
        do_mult(1'b0, 0, 1, 3, 1'b0, 1'b0, 1'b0, dl, ex, to, hb, bb);
        checks++; if (hb) begin errors++; $display("FAIL bp_hold: row/idx changed during stall, got flag %0d expected 0", hb); end
        checks++; if (dl != LAT + 3) begin errors++; $display("FAIL bp_latency: got %0d expected %0d", dl, LAT + 3); end
        checks++; if (n_got != N) begin errors++; $display("FAIL bp_row_count: got %0d expected %0d", n_got, N); end
        for (int r = 0; r < N; r++) begin
            checks++; if (got_idx[r] != r) begin errors++; $display("FAIL bp_idx%0d: got %0d expected %0d", r, got_idx[r], r); end
            for (int j = 0; j < N; j++) begin
                checks++;
                if (got_row[r][j*ACC +: ACC] !== c_exp[r][j]) begin
                    errors++; $display("FAIL bp_c%0d%0d: got %0h expected %0h", r, j, got_row[r][j*ACC +: ACC], c_exp[r][j]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int dl, ex; bit to, hb, bb; bit dn;
        load_case1();
        @(negedge clk);
        ifc.start_i = 1'b1; ifc.signed_i = 1'b0;
        @(negedge clk);
        ifc.start_i = 1'b0;
        for (int k = 0; k < N; k++) begin
            ifc.in_valid_i = 1'b1;
            for (int i = 0; i < N; i++) begin
                ifc.a_col_i[i*DW +: DW] = DW'(a_m[i][k]);
                ifc.b_row_i[i*DW +: DW] = DW'(b_m[k][i]);
            end
            @(negedge clk);
        end
        ifc.in_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (ifc.busy_o !== 1'b1) begin errors++; $display("FAIL rstmid_pre_busy: got %b expected 1", ifc.busy_o); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (ifc.busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", ifc.busy_o); end
        checks++; if (ifc.res_valid_o !== 1'b0 || ifc.in_ready_o !== 1'b0 || ifc.done_o !== 1'b0) begin
            errors++; $display("FAIL rstmid_ctrl: got valid %b ready %b done %b expected 0 0 0", ifc.res_valid_o, ifc.in_ready_o, ifc.done_o);
        end
        checks++; if (ifc.res_row_o !== '0 || ifc.res_idx_o !== '0) begin
            errors++; $display("FAIL rstmid_data: got row %h idx %0d expected 0 0", ifc.res_row_o, ifc.res_idx_o);
        end
        dn = 0;
        repeat (20) begin
            if (ifc.done_o === 1'b1 || ifc.res_valid_o === 1'b1) dn = 1;
            @(negedge clk);
        end
        checks++; if (dn) begin errors++; $display("FAIL rstmid_no_done: got activity after abort, expected none"); end
        compute_model(1'b0);
        do_mult(1'b0, 0, -1, 0, 1'b0, 1'b0, 1'b0, dl, ex, to, hb, bb);
        checks++; if (dl != LAT) begin errors++; $display("FAIL rstmid_latency: got %0d expected %0d", dl, LAT); end
        for (int r = 0; r < N; r++)
            for (int j = 0; j < N; j++) begin
                checks++;
                if (got_row[r][j*ACC +: ACC] !== c_exp[r][j]) begin
                    errors++; $display("FAIL rstmid_c%0d%0d: got %0h expected %0h", r, j, got_row[r][j*ACC +: ACC], c_exp[r][j]);
                end
            end
    endtask

    task automatic test_back_to_back();
        int dl, ex; bit to, hb, bb;
        load_case1();
        compute_model(1'b0);
        do_mult(1'b0, 0, -1, 0, 1'b1, 1'b0, 1'b1, dl, ex, to, hb, bb);
        checks++; if (dl != LAT) begin errors++; $display("FAIL b2b_first_latency: got %0d expected %0d", dl, LAT); end
        for (int r = 0; r < N; r++)
            for (int j = 0; j < N; j++) begin
                checks++;
                if (got_row[r][j*ACC +: ACC] !== c_exp[r][j]) begin
                    errors++; $display("FAIL b2b_first_c%0d%0d: got %0h expected %0h", r, j, got_row[r][j*ACC +: ACC], c_exp[r][j]);
                end
            end
        load_const(1, 1);
        compute_model(1'b0);
        do_mult(1'b0, 0, -1, 0, 1'b1, 1'b1, 1'b0, dl, ex, to, hb, bb);
        checks++; if (dl != LAT) begin errors++; $display("FAIL b2b_second_latency: got %0d expected %0d", dl, LAT); end
        checks++; if (n_got != N) begin errors++; $display("FAIL b2b_second_rows: got %0d expected %0d", n_got, N); end
        for (int r = 0; r < N; r++)
            for (int j = 0; j < N; j++) begin
                checks++;
                if (got_row[r][j*ACC +: ACC] !== c_exp[r][j] || got_row[r][j*ACC +: ACC] !== ACC'(4)) begin
                    errors++; $display("FAIL b2b_second_c%0d%0d: got %0h expected 4", r, j, got_row[r][j*ACC +: ACC]);
                end
            end
        repeat (2) @(negedge clk);
        checks++; if (ifc.busy_o !== 1'b0) begin errors++; $display("FAIL b2b_no_queued_start: busy got %b expected 0", ifc.busy_o); end
    endtask

    task automatic test_random();
        int dl, ex; bit to, hb, bb; bit sgn; int srow, scyc;
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    a_m[i][j] = int'($urandom_range(0, 255));
                    b_m[i][j] = int'($urandom_range(0, 255));
                end
            sgn  = 1'($urandom_range(0, 1));
            srow = int'($urandom_range(0, N - 1));
            scyc = int'($urandom_range(0, 3));
            compute_model(sgn);
            do_mult(sgn, -1, srow, scyc, 1'b0, 1'b0, 1'b0, dl, ex, to, hb, bb);
            checks++; if (dl != LAT + ex) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", t, dl, LAT + ex); end
            checks++; if (hb || bb || n_got != N) begin
                errors++; $display("FAIL rnd%0d_stream: got hold %0d busy %0d rows %0d expected 0 0 %0d", t, hb, bb, n_got, N);
            end
            for (int r = 0; r < N; r++)
                for (int j = 0; j < N; j++) begin
                    checks++;
                    if (got_row[r][j*ACC +: ACC] !== c_exp[r][j]) begin
                        errors++; $display("FAIL rnd%0d_c%0d%0d: got %0h expected %0h", t, r, j, got_row[r][j*ACC +: ACC], c_exp[r][j]);
                    end
                end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_signed_mode();
        test_bubbles();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before time limit");
        $fatal(1);
    end

endmodule
